// File: rtl/dsp_config_loader.sv
// Serial writer for the DSP slice configuration scan chain: host words in, one bit per clock out.
// Optional readback check of the whole chain via CRC-16-CCITT, enabled by defining CFG_READBACK_EN.
`timescale 1ns/1ps
module dsp_config_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              configuration_input,
  output logic              configuration_enable,
  input  logic              configuration_output,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
`ifdef CFG_READBACK_EN
  localparam logic [2:0] VERIFY = 3'd3;
`endif
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     remaining_q, remaining_d, rem_dec;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;

`ifdef CFG_READBACK_EN
  logic [15:0] crc_ld_q, crc_ld_d;
  logic [15:0] crc_rb_q, crc_rb_d;
  logic        error_q, error_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    remaining_d = remaining_q;
    bitcnt_d    = bitcnt_q;
    rem_dec     = remaining_q - CW'(1);
`ifdef CFG_READBACK_EN
    crc_ld_d    = crc_ld_q;
    crc_rb_d    = crc_rb_q;
    error_d     = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FETCH;
          remaining_d = CW'(CHAIN_LEN);
`ifdef CFG_READBACK_EN
          error_d     = 1'b0;
          crc_ld_d    = 16'hFFFF;
          crc_rb_d    = 16'hFFFF;
`endif
        end
      end
      FETCH: begin
        if (s_valid) begin
          sreg_d   = s_data;
          // Last word may carry fewer useful bits than WORD_W.
          bitcnt_d = (int'(remaining_q) >= WORD_W) ? BW'(WORD_W) : BW'(remaining_q);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d      = sreg_q >> 1;
        remaining_d = rem_dec;
        bitcnt_d    = bitcnt_q - BW'(1);
`ifdef CFG_READBACK_EN
        crc_ld_d    = crc_step(crc_ld_q, sreg_q[0]);
`endif
        if (bitcnt_q == BW'(1)) begin
          if (rem_dec != '0) begin
            state_d = FETCH;
          end else begin
`ifdef CFG_READBACK_EN
            state_d     = VERIFY;
            remaining_d = CW'(CHAIN_LEN);
`else
            state_d     = DONE;
`endif
          end
        end
      end
`ifdef CFG_READBACK_EN
      VERIFY: begin
        // Recirculating a full chain length leaves its contents unchanged.
        crc_rb_d    = crc_step(crc_rb_q, configuration_output);
        remaining_d = rem_dec;
        if (remaining_q == CW'(1)) begin
          state_d = DONE;
          error_d = (crc_rb_d != crc_ld_q);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      remaining_q <= '0;
      bitcnt_q    <= '0;
`ifdef CFG_READBACK_EN
      crc_ld_q    <= '0;
      crc_rb_q    <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      remaining_q <= remaining_d;
      bitcnt_q    <= bitcnt_d;
`ifdef CFG_READBACK_EN
      crc_ld_q    <= crc_ld_d;
      crc_rb_q    <= crc_rb_d;
      error_q     <= error_d;
`endif
    end
  end

  assign s_ready = (state_q == FETCH);
  assign done    = (state_q == DONE);

`ifdef CFG_READBACK_EN
  assign busy                 = (state_q == FETCH) || (state_q == SHIFT) || (state_q == VERIFY);
  assign configuration_enable = (state_q == SHIFT) || (state_q == VERIFY);
  assign error                = error_q;

  always_comb begin
    configuration_input = 1'b0;
    if (state_q == SHIFT)       configuration_input = sreg_q[0];
    else if (state_q == VERIFY) configuration_input = configuration_output;
  end
`else
  logic cfg_out_unused;
  assign cfg_out_unused       = configuration_output;
  assign busy                 = (state_q == FETCH) || (state_q == SHIFT);
  assign configuration_enable = (state_q == SHIFT);
  assign configuration_input  = (state_q == SHIFT) ? sreg_q[0] : 1'b0;
  assign error                = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_config_loader.sv
// Directed bench for dsp_config_loader with behavioural chain models (4-bit and 20-bit chains).
`timescale 1ns/1ps
module tb_dsp_config_loader;
`ifdef CFG_READBACK_EN
  localparam int VER = 20;
`else
  localparam int VER = 0;
`endif

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, sv4 = 1'b0;
  logic [7:0] sd4 = 8'h00;
  logic       rdy4, ci4, en4, busy4, done4, err4;
  logic [3:0] chain4 = 4'h0;

  logic        start20 = 1'b0, sv20 = 1'b0;
  logic [7:0]  sd20 = 8'h00;
  logic        rdy20, ci20, en20, busy20, done20, err20;
  logic [19:0] chain20 = 20'h0;
  logic [19:0] stuck20 = 20'h0;

  int hs4 = 0, hs20 = 0, en_cnt20 = 0;
  int checks = 0, failures = 0;

  dsp_config_loader #(.CHAIN_LEN(4), .WORD_W(8)) u4 (
    .clk(clk), .RST(RST), .start(start4), .s_data(sd4), .s_valid(sv4), .s_ready(rdy4),
    .configuration_input(ci4), .configuration_enable(en4), .configuration_output(chain4[3]),
    .busy(busy4), .done(done4), .error(err4)
  );

  dsp_config_loader #(.CHAIN_LEN(20), .WORD_W(8)) u20 (
    .clk(clk), .RST(RST), .start(start20), .s_data(sd20), .s_valid(sv20), .s_ready(rdy20),
    .configuration_input(ci20), .configuration_enable(en20), .configuration_output(chain20[19]),
    .busy(busy20), .done(done20), .error(err20)
  );

  // Chain models: head at bit 0, tail (returned bit) at the MSB.
  always @(posedge clk) begin
    if (en4) chain4 <= {chain4[2:0], ci4};
    if (en20) begin
      chain20  <= {chain20[18:0], ci20} & ~stuck20;
      en_cnt20 = en_cnt20 + 1;
    end
    if (sv4 && rdy4)   hs4  = hs4 + 1;
    if (sv20 && rdy20) hs20 = hs20 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load20(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input int stall, output int done_cyc, output int stall_bad,
                        output int resume_bad, output int hs_n, output int en_n);
    logic [7:0] words [3];
    int k, hb, eb, stall_left, presented_c;
    words[0] = w0; words[1] = w1; words[2] = w2;
    hb = hs20; eb = en_cnt20; stall_left = stall;
    stall_bad = 0; resume_bad = 0; done_cyc = -1; presented_c = -10;
    start20 = 1'b1; sv20 = 1'b0;
    tick();
    start20 = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c == presented_c + 1 && en20 !== 1'b1) resume_bad++;
      if (done20 === 1'b1) begin
        done_cyc = c;
        break;
      end
      k = hs20 - hb;
      if (k == 1 && stall_left > 0 && (rdy20 || stall_left < stall)) begin
        sv20 = 1'b0;
        if (rdy20 !== 1'b1 || en20 !== 1'b0) stall_bad++;
        stall_left--;
      end else if (k < 3) begin
        sv20 = 1'b1;
        sd20 = words[k];
        if (rdy20) presented_c = c;
      end else begin
        sv20 = 1'b0;
      end
      tick();
    end
    sv20 = 1'b0;
    hs_n = hs20 - hb;
    en_n = en_cnt20 - eb;
  endtask

  initial begin
    logic [11:0] en_v, ci_v, done_v, busy_v, rdy_v;
    int dc, sb, rb, hn, en;
    en_v = '0; ci_v = '0; done_v = '0; busy_v = '0; rdy_v = '0;

    tick(); tick();
    chk("reset_u4_outputs",  {rdy4, ci4, en4, busy4, done4, err4}, 6'b0);
    chk("reset_u20_outputs", {rdy20, ci20, en20, busy20, done20, err20}, 6'b0);
    RST = 1'b0;
    tick();

    // CHAIN_LEN=4: single word 0x0D, only low 4 bits used.
    start4 = 1'b1; sv4 = 1'b1; sd4 = 8'h0D;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      en_v[c] = en4; ci_v[c] = ci4; done_v[c] = done4; busy_v[c] = busy4; rdy_v[c] = rdy4;
      tick();
    end
    sv4 = 1'b0;
`ifdef CFG_READBACK_EN
    chk("c4_enable_cycles", en_v,   12'h3FC);
    chk("c4_serial_bits",   ci_v,   12'h374);
    chk("c4_done_cycle",    done_v, 12'h400);
    chk("c4_busy_cycles",   busy_v, 12'h3FE);
    chk("c4_error",         err4,   1'b0);
`else
    chk("c4_enable_cycles", en_v,   12'h03C);
    chk("c4_serial_bits",   ci_v,   12'h034);
    chk("c4_done_cycle",    done_v, 12'h040);
    chk("c4_busy_cycles",   busy_v, 12'h03E);
`endif
    chk("c4_ready_cycles",  rdy_v,  12'h002);
    chk("c4_chain_content", chain4, 4'b1011);
    chk("c4_handshakes",    hs4,    1);

    // CHAIN_LEN=20: 0xA5, 0x3C, 0xFF (only low nibble of last word shifted).
    load20(8'hA5, 8'h3C, 8'hFF, 0, dc, sb, rb, hn, en);
    chk("c20_done_cycle",  dc, 24 + VER);
    chk("c20_error",       err20, 1'b0);
    chk("c20_handshakes",  hn, 3);
    chk("c20_enables",     en, 20 + VER);
    chk("c20_chain",       chain20, 20'hA53CF);
    chk("c20_resume",      rb, 0);
    tick();

    // Stall of 5 cycles before the second word.
    load20(8'h12, 8'h34, 8'h56, 5, dc, sb, rb, hn, en);
    chk("stall_ready_enable", sb, 0);
    chk("stall_done_cycle",   dc, 29 + VER);
    chk("stall_handshakes",   hn, 3);
    chk("stall_enables",      en, 20 + VER);
    chk("stall_chain",        chain20, 20'h482C6);
    chk("stall_resume",       rb, 0);
    tick();

    // start and s_valid during SHIFT are ignored; RST mid-word clears immediately.
    hn = hs20;
    start20 = 1'b1;
    tick();
    start20 = 1'b0; sv20 = 1'b1; sd20 = 8'h77;
    tick();
    start20 = 1'b1;
    tick(); tick();
    chk("shift_ready_low",     rdy20, 1'b0);
    chk("shift_busy",          busy20, 1'b1);
    chk("shift_no_extra_word", hs20 - hn, 1);
    #2 RST = 1'b1;
    #1;
    chk("async_reset_outputs", {rdy20, ci20, en20, busy20, done20, err20}, 6'b0);
    start20 = 1'b0; sv20 = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    chk("idle_after_reset", {rdy20, ci20, en20, busy20, done20, err20}, 6'b0);
    start20 = 1'b1;
    tick();
    start20 = 1'b0;
    chk("fetch_from_idle", {rdy20, busy20}, 2'b11);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();

`ifdef CFG_READBACK_EN
    load20(8'hA5, 8'h3C, 8'h0F, 0, dc, sb, rb, hn, en);
    chk("rb_done_cycle", dc, 44);
    chk("rb_error_clean", err20, 1'b0);
    chk("rb_enables",     en, 40);
    chk("rb_chain_kept",  chain20, 20'hA53CF);
    tick();
    stuck20 = 20'h00400;
    load20(8'hFF, 8'hFF, 8'hFF, 0, dc, sb, rb, hn, en);
    chk("rb_stuck_done",  dc, 44);
    chk("rb_stuck_error", err20, 1'b1);
    tick();
    chk("rb_error_holds", err20, 1'b1);
    start20 = 1'b1;
    tick();
    start20 = 1'b0;
    chk("rb_error_cleared", {err20, rdy20}, 2'b01);
    stuck20 = 20'h0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
